// File: rtl/ahb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_rr_arbiter_if
// Arbitration signals shared between the requesting masters and the
// round-robin arbiter.
//   Hbusreq   [NUM_MASTERS] per-master bus request
//   Hlock     [NUM_MASTERS] per-master locked-access request
//   Htrans    [2]           transfer type of the current owner
//   Hburst    [3]           burst type of the current owner
//   Hreadyout [1]           slave ready, a transfer is accepted when 1
//   Hgrant    [NUM_MASTERS] one-hot grant
//   Hmaster   [MASTER_W]    owner of the current address phase
//   Hmastlock [1]           current address phase is locked
// Modports: slave  - the arbiter (consumes requests, produces grants)
//           master - the requesting side (produces requests, sees grants)
// ---------------------------------------------------------------------------
interface ahb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MASTER_W    = 2
);
  logic [NUM_MASTERS-1:0] Hbusreq;
  logic [NUM_MASTERS-1:0] Hlock;
  logic [1:0]             Htrans;
  logic [2:0]             Hburst;
  logic                   Hreadyout;
  logic [NUM_MASTERS-1:0] Hgrant;
  logic [MASTER_W-1:0]    Hmaster;
  logic                   Hmastlock;

  modport slave (
    input  Hbusreq, Hlock, Htrans, Hburst, Hreadyout,
    output Hgrant, Hmaster, Hmastlock
  );

  modport master (
    output Hbusreq, Hlock, Htrans, Hburst, Hreadyout,
    input  Hgrant, Hmaster, Hmastlock
  );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_rr_arbiter
// Round-robin AHB bus arbiter. Produces a registered one-hot grant, the
// address-phase owner index and the locked flag. Grants never move inside a
// fixed-length burst or a locked sequence. No datapath: the external address
// mux is steered by Hmaster.
// Ports:
//   Hclk    bus clock, all state changes on the rising edge
//   Hreset  synchronous active-high reset
//   bus     ahb_rr_arbiter_if.slave (requests in, grant/owner/lock out)
// ---------------------------------------------------------------------------
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MASTER_W       = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  ahb_rr_arbiter_if.slave       bus
);

  typedef enum logic [1:0] {PARK, OWNED, BURST, LOCKED} state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [MASTER_W-1:0]    DEF_IDX   = MASTER_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [MASTER_W-1:0]    master_q;
  logic                   mastlock_q;
  logic [MASTER_W-1:0]    rr_ptr_q;
  logic [3:0]             beat_cnt_q;
  logic [3:0]             beat_cnt_d;

  logic [MASTER_W-1:0]    g_idx;
  logic                   lock_hold;
  logic                   arb_point;
  logic                   any_req;
  logic                   found;
  logic [MASTER_W-1:0]    sel_idx;

  // Beats remaining after the first one, for a NONSEQ of the given burst.
  function automatic logic [3:0] burst_last(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: burst_last = 4'd3;
      3'b100, 3'b101: burst_last = 4'd7;
      3'b110, 3'b111: burst_last = 4'd15;
      default:        burst_last = 4'd0;  // SINGLE and undefined-length INCR
    endcase
  endfunction

  function automatic logic [MASTER_W-1:0] wrap_idx(input int unsigned v);
    return MASTER_W'(v % NUM_MASTERS);
  endfunction

  // NOTE: every output of a combinational block gets a default before any
  // branch, otherwise an unassigned path infers a latch.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    case (bus.Htrans)
      HTRANS_NONSEQ: beat_cnt_d = burst_last(bus.Hburst);
      HTRANS_SEQ:    if (beat_cnt_q != 4'd0) beat_cnt_d = beat_cnt_q - 4'd1;
      HTRANS_BUSY:   beat_cnt_d = beat_cnt_q;
      HTRANS_IDLE:   beat_cnt_d = 4'd0;
      default:       beat_cnt_d = beat_cnt_q;
    endcase
  end

  // Index of the currently granted master (grant_q is one-hot).
  always_comb begin
    g_idx = DEF_IDX;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) g_idx = MASTER_W'(i);
    end
  end

  // Round-robin search starting just after the last winner. The last slot
  // visited is rr_ptr itself, so a lone requester keeps the bus.
  always_comb begin
    found   = 1'b0;
    sel_idx = DEF_IDX;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!found && bus.Hbusreq[wrap_idx(int'(rr_ptr_q) + k)]) begin
        found   = 1'b1;
        sel_idx = wrap_idx(int'(rr_ptr_q) + k);
      end
    end
  end

  assign any_req   = |bus.Hbusreq;
  assign lock_hold = bus.Hlock[g_idx] & bus.Hbusreq[g_idx];
  // beat_cnt_d == 1 lets the grant move during the last beat's address
  // phase, so the next owner starts without a dead cycle.
  assign arb_point = (beat_cnt_d <= 4'd1) && !lock_hold;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q    <= PARK;
      grant_q    <= DEF_GRANT;
      master_q   <= DEF_IDX;
      mastlock_q <= 1'b0;
      rr_ptr_q   <= DEF_IDX;
      beat_cnt_q <= 4'd0;
    end else if (bus.Hreadyout) begin
      // Wait states fall through this branch: everything holds.
      beat_cnt_q <= beat_cnt_d;
      master_q   <= g_idx;
      mastlock_q <= bus.Hlock[g_idx];

      if (arb_point) begin
        if (found) begin
          grant_q  <= NUM_MASTERS'(1) << sel_idx;
          rr_ptr_q <= sel_idx;
        end else begin
          grant_q  <= DEF_GRANT;
        end
      end

      case (state_q)
        PARK: begin
          if (arb_point && any_req) state_q <= OWNED;
        end
        OWNED: begin
          if (lock_hold)                     state_q <= LOCKED;
          else if (beat_cnt_d > 4'd1)        state_q <= BURST;
          else if (arb_point && !any_req)    state_q <= PARK;
        end
        BURST: begin
          // A lock raised on the final beat takes priority over release.
          if (lock_hold)                     state_q <= LOCKED;
          else if (beat_cnt_d <= 4'd1)       state_q <= OWNED;
        end
        LOCKED: begin
          if (!lock_hold) state_q <= (beat_cnt_d > 4'd1) ? BURST : OWNED;
        end
        default: state_q <= PARK;
      endcase
    end
  end

  assign bus.Hgrant    = grant_q;
  assign bus.Hmaster   = master_q;
  assign bus.Hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_rr_arbiter
// Directed scenarios followed by randomized traffic, with every accepted
// edge compared against a behavioural model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_ahb_rr_arbiter;

  localparam int N   = 4;
  localparam int W   = 2;
  localparam int DEF = 0;

  logic Hclk;
  logic Hreset;

  ahb_rr_arbiter_if #(.NUM_MASTERS(N), .MASTER_W(W)) bus ();

  ahb_rr_arbiter #(
    .NUM_MASTERS   (N),
    .MASTER_W      (W),
    .DEFAULT_MASTER(DEF)
  ) dut (
    .Hclk  (Hclk),
    .Hreset(Hreset),
    .bus   (bus.slave)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: granted master, round-robin pointer, beats left,
  // address-phase owner and its lock flag.
  int m_grant  = DEF;
  int m_ptr    = DEF;
  int m_cnt    = 0;
  int m_master = DEF;
  int m_lock   = 0;

  int len_tab [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model the edge from the spec rules, then compare.
  task automatic cycle(input string tag);
    int nc, ng, np, nm, nl;
    bit hold, found;
    nc = m_cnt; ng = m_grant; np = m_ptr; nm = m_master; nl = m_lock;
    if (Hreset) begin
      nc = 0; ng = DEF; np = DEF; nm = DEF; nl = 0;
    end else if (bus.Hreadyout) begin
      case (bus.Htrans)
        2'b10:   nc = len_tab[bus.Hburst] - 1;
        2'b11:   nc = (m_cnt > 0) ? m_cnt - 1 : m_cnt;
        2'b01:   nc = m_cnt;
        default: nc = 0;
      endcase
      nm   = m_grant;
      nl   = bus.Hlock[m_grant];
      hold = bus.Hlock[m_grant] && bus.Hbusreq[m_grant];
      if (nc <= 1 && !hold) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && bus.Hbusreq[(m_ptr + k) % N]) begin
            found = 1;
            ng    = (m_ptr + k) % N;
            np    = ng;
          end
        end
        if (!found) ng = DEF;
      end
    end
    @(posedge Hclk);
    #1;
    m_cnt = nc; m_grant = ng; m_ptr = np; m_master = nm; m_lock = nl;
    check({tag, ".grant"},    32'(bus.Hgrant),      32'(1 << m_grant));
    check({tag, ".master"},   32'(bus.Hmaster),     32'(m_master));
    check({tag, ".mastlock"}, 32'(bus.Hmastlock),   32'(m_lock));
    check({tag, ".beat_cnt"}, 32'(dut.beat_cnt_q),  32'(m_cnt));
    check({tag, ".onehot"},   32'($onehot(bus.Hgrant)), 32'(1));
  endtask

  initial begin
    // ---- Reset with every master requesting
    Hreset = 1'b1;
    bus.Hbusreq = 4'b1111; bus.Hlock = 4'b0000;
    bus.Htrans = 2'b00; bus.Hburst = 3'b000; bus.Hreadyout = 1'b1;
    cycle("rst0");
    cycle("rst1");
    check("rst.grant",    32'(bus.Hgrant),    32'h1);
    check("rst.master",   32'(bus.Hmaster),   32'h0);
    check("rst.mastlock", 32'(bus.Hmastlock), 32'h0);

    // ---- Rotation on SINGLE NONSEQ transfers
    Hreset = 1'b0; bus.Htrans = 2'b10; bus.Hburst = 3'b000;
    cycle("rot1"); check("rot1.lit", 32'(bus.Hgrant), 32'h2);
    cycle("rot2"); check("rot2.lit", 32'(bus.Hgrant), 32'h4);
    cycle("rot3"); check("rot3.lit", 32'(bus.Hgrant), 32'h8);
    cycle("rot4"); check("rot4.lit", 32'(bus.Hgrant), 32'h1);

    // ---- INCR4 by M1 while M2 requests
    bus.Hbusreq = 4'b0110; bus.Htrans = 2'b00;
    cycle("incr4.own"); check("incr4.own.lit", 32'(bus.Hgrant), 32'h2);
    bus.Htrans = 2'b10; bus.Hburst = 3'b011;
    cycle("incr4.b1"); check("incr4.b1.lit", 32'(bus.Hgrant), 32'h2);
    bus.Htrans = 2'b11;
    cycle("incr4.b2"); check("incr4.b2.lit", 32'(bus.Hgrant), 32'h2);
    cycle("incr4.b3"); check("incr4.b3.lit", 32'(bus.Hgrant), 32'h4);
    bus.Hbusreq = 4'b0100;
    cycle("incr4.b4"); check("incr4.b4.lit", 32'(bus.Hmaster), 32'h2);

    // ---- WRAP8 by M2 with three wait states
    bus.Htrans = 2'b10; bus.Hburst = 3'b100;
    cycle("wrap8.b1");
    bus.Hbusreq = 4'b0110; bus.Htrans = 2'b11;
    cycle("wrap8.b2");
    cycle("wrap8.b3");
    bus.Hreadyout = 1'b0;
    for (int i = 0; i < 3; i++) cycle("wrap8.wait");
    check("wrap8.wait.grant", 32'(bus.Hgrant),     32'h4);
    check("wrap8.wait.cnt",   32'(dut.beat_cnt_q), 32'h5);
    bus.Hreadyout = 1'b1;
    cycle("wrap8.b4");
    cycle("wrap8.b5");
    cycle("wrap8.b6"); check("wrap8.b6.lit", 32'(bus.Hgrant), 32'h4);
    cycle("wrap8.b7"); check("wrap8.b7.lit", 32'(bus.Hgrant), 32'h2);
    bus.Hbusreq = 4'b0010;
    cycle("wrap8.b8");

    // ---- Locked sequence by M3 while M0 requests
    bus.Hbusreq = 4'b1000; bus.Htrans = 2'b00;
    cycle("lock.own");
    bus.Hlock = 4'b1000; bus.Hbusreq = 4'b1001;
    bus.Htrans = 2'b10; bus.Hburst = 3'b000;
    for (int i = 0; i < 5; i++) begin
      cycle("lock.hold");
      check("lock.hold.grant", 32'(bus.Hgrant),    32'h8);
      check("lock.hold.mlock", 32'(bus.Hmastlock), 32'h1);
    end
    bus.Hlock = 4'b0000;
    cycle("lock.rel"); check("lock.rel.lit", 32'(bus.Hgrant), 32'h1);

    // ---- Parking with M2 as owner
    bus.Hbusreq = 4'b0100; bus.Htrans = 2'b00;
    cycle("park.own");
    bus.Hbusreq = 4'b0000;
    cycle("park.p1"); check("park.p1.lit", 32'(bus.Hgrant), 32'h1);
    cycle("park.p2"); check("park.p2.lit", 32'(bus.Hmaster), 32'h0);

    // ---- Reset during beat 5 of an INCR16 by M1
    bus.Hbusreq = 4'b0010;
    cycle("r16.own");
    bus.Htrans = 2'b10; bus.Hburst = 3'b111;
    cycle("r16.b1");
    bus.Htrans = 2'b11;
    for (int i = 0; i < 3; i++) cycle("r16.seq");
    Hreset = 1'b1;
    cycle("r16.rst");
    check("r16.rst.grant", 32'(bus.Hgrant),     32'h1);
    check("r16.rst.cnt",   32'(dut.beat_cnt_q), 32'h0);
    Hreset = 1'b0; bus.Htrans = 2'b00;
    cycle("r16.regrant"); check("r16.regrant.lit", 32'(bus.Hgrant), 32'h2);

    // ---- Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.Hbusreq   = 4'($urandom);
      bus.Hlock     = 4'($urandom) & 4'($urandom) & 4'($urandom);
      bus.Htrans    = 2'($urandom);
      bus.Hburst    = 3'($urandom);
      bus.Hreadyout = ($urandom_range(0, 3) != 0);
      Hreset        = ($urandom_range(0, 49) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
